// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM port arbiter: FSM state encoding,
// requester IDs and default address/data widths.
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 9;
  localparam int SRAM_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DATA  = 3'd2,
    ST_IF_LO = 3'd3,
    ST_IF_HI = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    RID_NONE = 2'd0,
    RID_L    = 2'd1,
    RID_I    = 2'd2,
    RID_D    = 2'd3
  } req_id_t;

  // A new grant may be issued from any state except the first half of a fetch.
  function automatic logic arb_point(arb_state_t s);
    return s != ST_IF_LO;
  endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way instruction/data picker. Define SRAM_ARB_ROUND_ROBIN_EN for
// alternating service; otherwise data always wins over instruction fetch.
module sram_rr_arb2 (
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic rst,
  input  logic take,
`endif
  input  logic i_req,
  input  logic d_req,
  output logic pick_i,
  output logic pick_d
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic favour_d;

  // After an I grant D is favoured next, and vice versa.
  always_ff @(posedge clk) begin
    if (rst) begin
      favour_d <= 1'b1;
    end else if (take && (i_req || d_req)) begin
      favour_d <= pick_i;
    end
  end

  always_comb begin
    pick_d = d_req && (!i_req || favour_d);
    pick_i = i_req && (!d_req || !favour_d);
  end
`else
  always_comb begin
    pick_d = d_req;
    pick_i = i_req && !d_req;
  end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter for loader (L), instruction fetch (I) and data (D).
// Optional SRAM_ARB_ROUND_ROBIN_EN selects round-robin I/D arbitration.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_W,
  parameter int DATA_WIDTH = SRAM_DATA_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    L_REQ,
  input  logic                    L_WE,
  input  logic [ADDR_WIDTH-1:0]   L_ADDR,
  input  logic [DATA_WIDTH-1:0]   L_WDATA,
  output logic                    L_GNT,
  output logic                    L_RVLD,
  output logic [DATA_WIDTH-1:0]   L_RDATA,
  input  logic                    I_REQ,
  input  logic [ADDR_WIDTH-2:0]   I_ADDR,
  output logic                    I_GNT,
  output logic                    I_VLD,
  output logic [2*DATA_WIDTH-1:0] I_DATA,
  input  logic                    D_REQ,
  input  logic                    D_WE,
  input  logic [ADDR_WIDTH-1:0]   D_ADDR,
  input  logic [DATA_WIDTH-1:0]   D_WDATA,
  output logic                    D_GNT,
  output logic                    D_RVLD,
  output logic [DATA_WIDTH-1:0]   D_RDATA,
  output logic [ADDR_WIDTH-1:0]   M_A,
  output logic                    M_CEN,
  output logic                    M_WE,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  output logic                    BUSY
);

  arb_state_t            st;
  req_id_t               winner;
  logic                  pick_i;
  logic                  pick_d;
  logic [DATA_WIDTH-1:0] lo_byte;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic arb_take;
  assign arb_take = arb_point(st) && !L_REQ;
`endif

  sram_rr_arb2 u_rr (
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    .clk    (CLK),
    .rst    (RST),
    .take   (arb_take),
`endif
    .i_req  (I_REQ),
    .d_req  (D_REQ),
    .pick_i (pick_i),
    .pick_d (pick_d)
  );

  always_comb begin
    winner = RID_NONE;
    if (L_REQ)       winner = RID_L;
    else if (pick_d) winner = RID_D;
    else if (pick_i) winner = RID_I;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st      <= ST_IDLE;
      L_GNT   <= 1'b0;
      I_GNT   <= 1'b0;
      D_GNT   <= 1'b0;
      L_RVLD  <= 1'b0;
      D_RVLD  <= 1'b0;
      I_VLD   <= 1'b0;
      M_CEN   <= 1'b1;
      M_WE    <= 1'b0;
      M_A     <= '0;
      M_WDATA <= '0;
      lo_byte <= '0;
    end else begin
      L_GNT  <= 1'b0;
      I_GNT  <= 1'b0;
      D_GNT  <= 1'b0;
      // Read data returns one cycle after the access cycle, so validity
      // follows the state being left rather than the one being entered.
      L_RVLD <= (st == ST_LOAD) && !M_WE;
      D_RVLD <= (st == ST_DATA) && !M_WE;
      I_VLD  <= (st == ST_IF_HI);
      if (st == ST_IF_HI) lo_byte <= M_RDATA;

      if (!arb_point(st)) begin
        st     <= ST_IF_HI;
        M_A[0] <= 1'b1;
      end else begin
        unique case (winner)
          RID_L: begin
            st      <= ST_LOAD;
            L_GNT   <= 1'b1;
            M_CEN   <= 1'b0;
            M_A     <= L_ADDR;
            M_WE    <= L_WE;
            M_WDATA <= L_WE ? L_WDATA : '0;
          end
          RID_D: begin
            st      <= ST_DATA;
            D_GNT   <= 1'b1;
            M_CEN   <= 1'b0;
            M_A     <= D_ADDR;
            M_WE    <= D_WE;
            M_WDATA <= D_WE ? D_WDATA : '0;
          end
          RID_I: begin
            st      <= ST_IF_LO;
            I_GNT   <= 1'b1;
            M_CEN   <= 1'b0;
            M_A     <= {I_ADDR, 1'b0};
            M_WE    <= 1'b0;
            M_WDATA <= '0;
          end
          default: begin
            st      <= ST_IDLE;
            M_CEN   <= 1'b1;
            M_A     <= '0;
            M_WE    <= 1'b0;
            M_WDATA <= '0;
          end
        endcase
      end
    end
  end

  assign L_RDATA = L_RVLD ? M_RDATA : '0;
  assign D_RDATA = D_RVLD ? M_RDATA : '0;
  assign I_DATA  = I_VLD ? {M_RDATA, lo_byte} : '0;
  assign BUSY    = (st != ST_IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter against a transaction-level schedule
// model; honours SRAM_ARB_ROUND_ROBIN_EN for the I/D arbitration rule.
module tb_sram_port_arbiter;

  localparam int MAXC = 2048;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        L_REQ = 1'b0, L_WE = 1'b0;
  logic [8:0]  L_ADDR = '0;
  logic [7:0]  L_WDATA = '0;
  logic        L_GNT, L_RVLD;
  logic [7:0]  L_RDATA;
  logic        I_REQ = 1'b0;
  logic [7:0]  I_ADDR = '0;
  logic        I_GNT, I_VLD;
  logic [15:0] I_DATA;
  logic        D_REQ = 1'b0, D_WE = 1'b0;
  logic [8:0]  D_ADDR = '0;
  logic [7:0]  D_WDATA = '0;
  logic        D_GNT, D_RVLD;
  logic [7:0]  D_RDATA;
  logic [8:0]  M_A;
  logic        M_CEN, M_WE;
  logic [7:0]  M_WDATA;
  logic [7:0]  M_RDATA;
  logic        BUSY;

  sram_port_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .L_REQ(L_REQ), .L_WE(L_WE), .L_ADDR(L_ADDR), .L_WDATA(L_WDATA),
    .L_GNT(L_GNT), .L_RVLD(L_RVLD), .L_RDATA(L_RDATA),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_VLD(I_VLD), .I_DATA(I_DATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_RVLD(D_RVLD), .D_RDATA(D_RDATA),
    .M_A(M_A), .M_CEN(M_CEN), .M_WE(M_WE), .M_WDATA(M_WDATA), .M_RDATA(M_RDATA),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] init_byte(int a);
    return 8'((a * 37 + 11) ^ (a >> 2));
  endfunction

  // External SRAM: registered read, data valid the cycle after the address.
  bit [7:0] sram   [512];
  bit       sram_w [512];
  always @(posedge CLK) begin
    if (!M_CEN) begin
      if (M_WE) begin
        sram[M_A]   <= M_WDATA;
        sram_w[M_A] <= 1'b1;
      end else begin
        M_RDATA <= sram_w[M_A] ? sram[M_A] : init_byte(int'(M_A));
      end
    end
  end

  typedef struct {
    bit        lg, ig, dg, cen, we, lv, dv, iv;
    bit [8:0]  a;
    bit [7:0]  wd, ld, dd;
    bit [15:0] id;
  } exp_t;

  exp_t       exp_q [MAXC];
  exp_t       idle_e;
  logic [7:0] ref_mem [512];
  int         cyc = 0;
  int         busy_until = 0;
  bit         favour_i = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Single-byte access by L (is_l=1) or D: granted next cycle, read data a cycle later.
  task automatic sched_byte(input bit is_l, input bit we, input bit [8:0] a, input bit [7:0] wd);
    int c = cyc + 1;
    exp_q[c].cen = 1'b0;
    exp_q[c].we  = we;
    exp_q[c].a   = a;
    exp_q[c].wd  = we ? wd : 8'h00;
    if (is_l) exp_q[c].lg = 1'b1; else exp_q[c].dg = 1'b1;
    if (we) ref_mem[a] = wd;
    else if (is_l) begin exp_q[c+1].lv = 1'b1; exp_q[c+1].ld = ref_mem[a]; end
    else begin exp_q[c+1].dv = 1'b1; exp_q[c+1].dd = ref_mem[a]; end
    busy_until = c;
  endtask

  task automatic sched_fetch(input bit [7:0] w);
    int c  = cyc + 1;
    int a0 = (int'(w) * 2) % 512;
    int a1 = (a0 + 1) % 512;
    exp_q[c].ig    = 1'b1;
    exp_q[c].cen   = 1'b0;
    exp_q[c].a     = 9'(a0);
    exp_q[c+1].cen = 1'b0;
    exp_q[c+1].a   = 9'(a1);
    exp_q[c+2].iv  = 1'b1;
    exp_q[c+2].id  = {ref_mem[a1], ref_mem[a0]};
    busy_until = c + 1;
  endtask

  // Decide what the edge ending the current cycle does, from current inputs.
  task automatic model_eval();
    bit take_i;
    if (RST) begin
      for (int c = cyc + 1; c < MAXC; c++) exp_q[c] = idle_e;
      busy_until = cyc;
      favour_i = 1'b0;
      return;
    end
    if (busy_until > cyc) return;
    if (L_REQ) begin
      sched_byte(1'b1, L_WE, L_ADDR, L_WDATA);
      return;
    end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    take_i = I_REQ && (!D_REQ || favour_i);
`else
    take_i = I_REQ && !D_REQ;
`endif
    if (take_i) begin
      sched_fetch(I_ADDR);
      favour_i = 1'b0;
    end else if (D_REQ) begin
      sched_byte(1'b0, D_WE, D_ADDR, D_WDATA);
      favour_i = 1'b1;
    end
  endtask

  task automatic check_outputs();
    exp_t e = exp_q[cyc];
    chk("l_gnt",  32'(L_GNT),  32'(e.lg));
    chk("i_gnt",  32'(I_GNT),  32'(e.ig));
    chk("d_gnt",  32'(D_GNT),  32'(e.dg));
    chk("m_cen",  32'(M_CEN),  32'(e.cen));
    chk("busy",   32'(BUSY),   32'(!e.cen));
    chk("m_a",    32'(M_A),    32'(e.a));
    chk("m_we",   32'(M_WE),   32'(e.we));
    if (e.cen || e.we) chk("m_wdata", 32'(M_WDATA), 32'(e.wd));
    chk("l_rvld", 32'(L_RVLD), 32'(e.lv));
    chk("d_rvld", 32'(D_RVLD), 32'(e.dv));
    chk("i_vld",  32'(I_VLD),  32'(e.iv));
    if (e.lv) chk("l_rdata", 32'(L_RDATA), 32'(e.ld));
    if (e.dv) chk("d_rdata", 32'(D_RDATA), 32'(e.dd));
    if (e.iv) chk("i_data",  32'(I_DATA),  32'(e.id));
  endtask

  task automatic next_cycle();
    model_eval();
    @(posedge CLK);
    #1;
    cyc++;
    check_outputs();
    if (exp_q[cyc].lg) L_REQ = 1'b0;
    if (exp_q[cyc].ig) I_REQ = 1'b0;
    if (exp_q[cyc].dg) D_REQ = 1'b0;
  endtask

  task automatic post_l(input bit we, input bit [8:0] a, input bit [7:0] d);
    L_REQ = 1'b1; L_WE = we; L_ADDR = a; L_WDATA = d;
  endtask
  task automatic post_i(input bit [7:0] a);
    I_REQ = 1'b1; I_ADDR = a;
  endtask
  task automatic post_d(input bit we, input bit [8:0] a, input bit [7:0] d);
    D_REQ = 1'b1; D_WE = we; D_ADDR = a; D_WDATA = d;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    next_cycle();
    next_cycle();
    RST = 1'b0;
  endtask

  int gseq [16];
  int ng;
  int ni;

  initial begin
    idle_e = '{default: 0};
    idle_e.cen = 1'b1;
    for (int c = 0; c < MAXC; c++) exp_q[c] = idle_e;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_byte(i);

    do_reset();
    chk("rst_i_data",  32'(I_DATA),  32'h0);
    chk("rst_d_rdata", 32'(D_RDATA), 32'h0);
    chk("rst_l_rdata", 32'(L_RDATA), 32'h0);

    // Loader write then data read of the same byte.
    post_l(1'b1, 9'h020, 8'h5A);
    next_cycle();
    chk("ld_wr_gnt", 32'(L_GNT), 32'h1);
    chk("ld_wr_we",  32'(M_WE),  32'h1);
    post_d(1'b0, 9'h020, 8'h00);
    next_cycle();
    chk("ld_wr_we_off", 32'(M_WE), 32'h0);
    next_cycle();
    chk("d_rd_vld",  32'(D_RVLD),  32'h1);
    chk("d_rd_data", 32'(D_RDATA), 32'h5A);

    // Preload 32/33 and fetch word 0x10.
    post_l(1'b1, 9'd32, 8'h04);
    next_cycle();
    post_l(1'b1, 9'd33, 8'hD3);
    next_cycle();
    post_i(8'h10);
    next_cycle();
    chk("if_lo_addr", 32'(M_A), 32'd32);
    next_cycle();
    chk("if_hi_addr", 32'(M_A), 32'd33);
    next_cycle();
    chk("if_vld",  32'(I_VLD),  32'h1);
    chk("if_data", 32'(I_DATA), 32'hD304);

    // Loader request raised during IF_LO waits for IF_HI.
    post_i(8'h11);
    next_cycle();
    post_l(1'b0, 9'h021, 8'h00);
    next_cycle();
    chk("atomic_no_lgnt", 32'(L_GNT), 32'h0);
    next_cycle();
    chk("atomic_lgnt", 32'(L_GNT), 32'h1);
    repeat (3) next_cycle();

    // Reset in IF_HI discards the fetch.
    post_i(8'h12);
    next_cycle();
    next_cycle();
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
    chk("rst_if_vld",  32'(I_VLD), 32'h0);
    chk("rst_if_cen",  32'(M_CEN), 32'h1);
    chk("rst_if_busy", 32'(BUSY),  32'h0);
    next_cycle();
    chk("rst_if_vld2", 32'(I_VLD), 32'h0);

    // Top word: bytes 510/511.
    post_i(8'hFF);
    next_cycle();
    chk("top_lo_addr", 32'(M_A), 32'd510);
    next_cycle();
    chk("top_hi_addr", 32'(M_A), 32'd511);
    next_cycle();
    chk("top_data", 32'(I_DATA), 32'({ref_mem[511], ref_mem[510]}));

    // I and D held continuously.
    do_reset();
    post_i(8'h05);
    post_d(1'b0, 9'h010, 8'h00);
    ng = 0;
    ni = 0;
    for (int k = 0; k < 16; k++) begin
      next_cycle();
      if (D_GNT && ng < 16) begin gseq[ng] = 2; ng++; end
      if (I_GNT && ng < 16) begin gseq[ng] = 1; ng++; ni++; end
      if (!I_REQ) post_i(8'h05);
      if (!D_REQ) post_d(1'b0, 9'h010, 8'h00);
    end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    chk("rr_cnt", 32'(ng >= 4), 32'h1);
    chk("rr_seq0", 32'(gseq[0]), 32'd2);
    chk("rr_seq1", 32'(gseq[1]), 32'd1);
    chk("rr_seq2", 32'(gseq[2]), 32'd2);
    chk("rr_seq3", 32'(gseq[3]), 32'd1);
`else
    chk("fixed_cnt", 32'(ng >= 8), 32'h1);
    chk("fixed_no_i", 32'(ni), 32'd0);
`endif
    I_REQ = 1'b0;
    D_REQ = 1'b0;
    repeat (4) next_cycle();

    // Random traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if (!L_REQ && $urandom_range(0, 9) == 0)
        post_l(1'($urandom), 9'($urandom_range(0, 63)), 8'($urandom));
      if (!I_REQ && $urandom_range(0, 3) == 0)
        post_i(($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31)));
      if (!D_REQ && $urandom_range(0, 3) == 0)
        post_d(1'($urandom), 9'($urandom_range(0, 63)), 8'($urandom));
      RST = ($urandom_range(0, 199) == 0);
      next_cycle();
      RST = 1'b0;
    end
    L_REQ = 1'b0;
    I_REQ = 1'b0;
    D_REQ = 1'b0;
    repeat (6) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, SRAM byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, SRAM byte width.
REQ-003 SHALL have port CLK  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-005 SHALL have ports L_REQ in 1, L_WE in 1, L_ADDR in 9, L_WDATA in 8: serial-loader (SRAM_IO_CTRL side) request, write flag, byte address, write data.
REQ-006 SHALL have ports L_GNT out 1, L_RVLD out 1, L_RDATA out 8: loader grant, read-valid, read data.
REQ-007 SHALL have ports I_REQ in 1, I_ADDR in 8: CPU instruction-fetch request and word address; byte address is {I_ADDR,1'b0}.
REQ-008 SHALL have ports I_GNT out 1, I_VLD out 1, I_DATA out 16: fetch grant, fetch-valid, assembled instruction.
REQ-009 SHALL have ports D_REQ in 1, D_WE in 1, D_ADDR in 9, D_WDATA in 8: CPU data request, write flag, byte address, write data.
REQ-010 SHALL have ports D_GNT out 1, D_RVLD out 1, D_RDATA out 8.
REQ-011 SHALL have ports M_A out 9, M_CEN out 1 (active-low), M_WE out 1, M_WDATA out 8, M_RDATA in 8: SRAM port; SRAM read is registered, data valid the cycle after the address.
REQ-012 SHALL have port BUSY out 1, high in every cycle an access is in flight.

Function
REQ-013 Requester SHALL hold REQ, address, WE and WDATA stable from REQ assertion until the cycle its GNT is high; GNT is a one-cycle pulse.
REQ-014 Arbitration SHALL be evaluated on registered state in IDLE or in the final cycle of an access (DATA, LOAD, IF_HI), allowing back-to-back accesses with no idle cycle.
REQ-015 Priority SHALL be: L highest; then I vs D per REQ-027/028.
REQ-016 FSM states SHALL be IDLE, LOAD, DATA, IF_LO, IF_HI; IF_LO SHALL always go to IF_HI (fetch pair atomic, never split by L_REQ).
REQ-017 Request seen at edge ending cycle t SHALL cause GNT high and M_A/M_WE/M_WDATA driven, M_CEN=0, in cycle t+1 (registered outputs).
REQ-018 Single-byte read granted in cycle t+1 SHALL produce xRVLD=1 and xRDATA=M_RDATA in cycle t+2, for exactly one cycle.
REQ-019 Writes SHALL complete in the grant cycle; no RVLD SHALL be produced for a write.
REQ-020 Fetch: IF_LO (cycle t+1) drives {I_ADDR,0}; IF_HI (t+2) drives {I_ADDR,1} and captures low byte; I_VLD=1 in t+3 with I_DATA={M_RDATA, low_byte} (little-endian).
REQ-021 When no access is granted: M_CEN=1, M_WE=0, M_A=0, M_WDATA=0.
REQ-022 RVLD/I_VLD of a completed access SHALL still be delivered when the next access is granted in the same cycle.
REQ-023 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; I_ADDR=8'hFF fetches bytes 510 and 511.

Reset
REQ-024 With RST=1 at an edge, FSM SHALL enter IDLE; all GNT, VLD, RVLD, BUSY, M_WE SHALL be 0, M_CEN=1, M_A=0, I_DATA=0, xRDATA=0, round-robin pointer SHALL favour D.
REQ-025 Reset mid-fetch or mid-read SHALL discard the access: no VLD/RVLD SHALL appear after reset.
REQ-026 RST SHALL take precedence over any simultaneous request.

Configuration
REQ-027 With SRAM_ARB_ROUND_ROBIN_EN defined, I vs D SHALL alternate when both request, pointer updated on each I or D grant.
REQ-028 Without SRAM_ARB_ROUND_ROBIN_EN, D SHALL always win over I (fixed priority).

Structure
REQ-029 Package sram_arb_pkg SHALL hold the FSM state enum, requester-ID encoding (L/I/D) and ADDR/DATA width constants.
REQ-030 The two-way I/D picker SHALL be sub-module sram_rr_arb2 (priority or round-robin per macro).

Verification
REQ-031 Loader write L_ADDR=9'h020, L_WDATA=8'h5A, then D read 9'h020 -> L_GNT pulse, M_WE=1 one cycle; D_RVLD with D_RDATA=8'h5A two cycles after request.
REQ-032 Preload bytes 32/33 = 8'h04/8'hD3, I_ADDR=8'h10 -> M_A=32 then 33 consecutive cycles, I_VLD with I_DATA=16'hD304 three cycles after request.
REQ-033 L_REQ raised during IF_LO -> IF_HI completes, L_GNT in the following cycle.
REQ-034 I_REQ and D_REQ held continuously -> macro on: grants alternate D,I,D,I; macro off: D only.
REQ-035 RST pulsed during IF_HI -> no I_VLD, M_CEN=1, BUSY=0 next cycle.
REQ-036 I_ADDR=8'hFF -> M_A=510 then 511, no wrap error.
